// File: rtl/hall_call_latch.sv
// Five-floor hall call latch: per-floor debounce, pending latch and car-service clear.
// Optional periodic re-issue of pending calls is enabled by defining HALL_CALL_REISSUE_EN.
//
// state    | meaning
// IDLE     | armed, waiting for a press
// DEBOUNCE | counting consecutive high samples
// PENDING  | call latched, waiting for a car
// RELEASE  | served while held; waits for button release
module hall_call_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REISSUE_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] raw_buttons,
  input  logic [2:0] ffloor,
  input  logic       fgoing_up,
  input  logic       fgoing_down,
  input  logic [2:0] sfloor,
  input  logic       sgoing_up,
  input  logic       sgoing_down,
  output logic [4:0] out_buttons,
  output logic [4:0] pending,
  output logic [2:0] pending_count
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PENDING, RELEASE} state_t;

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (REISSUE_CYCLES < 2 || REISSUE_CYCLES > 255) begin : g_bad_ri
    $error("REISSUE_CYCLES out of range");
  end

  state_t     state_q [5];
  state_t     state_d [5];
  logic [3:0] dcnt_q  [5];
  logic [3:0] dcnt_d  [5];
  logic [4:0] served;
  logic [4:0] pulse_d;
  logic [4:0] pending_d;
  logic [2:0] count_d;

`ifdef HALL_CALL_REISSUE_EN
  localparam logic [7:0] RI_LAST = 8'(REISSUE_CYCLES - 1);
  logic [7:0] rcnt_q [5];
  logic [7:0] rcnt_d [5];
`endif

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      served[i] = (ffloor == 3'(i + 1) && !fgoing_up && !fgoing_down) ||
                  (sfloor == 3'(i + 1) && !sgoing_up && !sgoing_down);
    end
  end

  always_comb begin
    pulse_d   = '0;
    pending_d = pending;
    count_d   = '0;
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
`ifdef HALL_CALL_REISSUE_EN
      rcnt_d[i]  = '0;
`endif
      case (state_q[i])
        IDLE: begin
          if (raw_buttons[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i]   = PENDING;
              pending_d[i] = 1'b1;
              pulse_d[i]   = 1'b1;
              dcnt_d[i]    = '0;
            end else begin
              state_d[i] = DEBOUNCE;
              dcnt_d[i]  = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          // Service aborts a press in progress before it can ever pulse.
          if (served[i]) begin
            state_d[i] = raw_buttons[i] ? RELEASE : IDLE;
            dcnt_d[i]  = '0;
          end else if (!raw_buttons[i]) begin
            state_d[i] = IDLE;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] >= DB_LAST) begin
            state_d[i]   = PENDING;
            pending_d[i] = 1'b1;
            pulse_d[i]   = 1'b1;
            dcnt_d[i]    = '0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + 4'd1;
          end
        end
        PENDING: begin
          if (served[i]) begin
            state_d[i]   = raw_buttons[i] ? RELEASE : IDLE;
            pending_d[i] = 1'b0;
          end
`ifdef HALL_CALL_REISSUE_EN
          else if (rcnt_q[i] == RI_LAST) begin
            pulse_d[i] = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 8'd1;
          end
`endif
        end
        RELEASE: begin
          if (!raw_buttons[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
    for (int i = 0; i < 5; i++) count_d = count_d + 3'(pending_d[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= '0;
`ifdef HALL_CALL_REISSUE_EN
        rcnt_q[i]  <= '0;
`endif
      end
      out_buttons   <= '0;
      pending       <= '0;
      pending_count <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
`ifdef HALL_CALL_REISSUE_EN
        rcnt_q[i]  <= rcnt_d[i];
`endif
      end
      out_buttons   <= pulse_d;
      pending       <= pending_d;
      pending_count <= count_d;
    end
  end

endmodule

// File: tb/tb_hall_call_latch.sv
// Self-checking bench for hall_call_latch: directed vector table, hand sequences,
// then random stimulus against a run-length based reference model.
module tb_hall_call_latch;
  localparam int DB = 4;
  localparam int RI = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raw_buttons;
  logic [2:0] ffloor, sfloor;
  logic       fgoing_up, fgoing_down, sgoing_up, sgoing_down;
  logic [4:0] out_buttons, pending;
  logic [2:0] pending_count;

  hall_call_latch #(.DEBOUNCE_CYCLES(DB), .REISSUE_CYCLES(RI)) dut (
    .clk(clk), .reset(reset), .raw_buttons(raw_buttons),
    .ffloor(ffloor), .fgoing_up(fgoing_up), .fgoing_down(fgoing_down),
    .sfloor(sfloor), .sgoing_up(sgoing_up), .sgoing_down(sgoing_down),
    .out_buttons(out_buttons), .pending(pending), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: consecutive-high run length, hold-off after service, pending, age since last pulse
  int m_run [5];
  int m_age [5];
  bit m_blk [5];
  bit m_pend[5];
  bit m_pulse[5];

  typedef struct {
    logic [4:0] raw;
    logic [2:0] ff; logic fu; logic fd;
    logic [2:0] sf; logic su; logic sd;
    logic [4:0] eo; logic [4:0] ep; logic [2:0] ec;
  } vec_t;
  vec_t tbl[25];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [4:0] eo, input logic [4:0] ep, input logic [2:0] ec);
    chk({name, ".out"},   {3'b0, out_buttons},   {3'b0, eo});
    chk({name, ".pend"},  {3'b0, pending},       {3'b0, ep});
    chk({name, ".count"}, {5'b0, pending_count}, {5'b0, ec});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_run[i] = 0; m_age[i] = 0; m_blk[i] = 0; m_pend[i] = 0; m_pulse[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 5; i++) begin
      bit sv, r;
      sv = (int'(ffloor) == i + 1 && !fgoing_up && !fgoing_down) ||
           (int'(sfloor) == i + 1 && !sgoing_up && !sgoing_down);
      r = raw_buttons[i];
      m_pulse[i] = 0;
      if (m_pend[i]) begin
        if (sv) begin
          m_pend[i] = 0; m_blk[i] = r;
        end else begin
`ifdef HALL_CALL_REISSUE_EN
          m_age[i]++;
          if (m_age[i] == RI) begin m_pulse[i] = 1; m_age[i] = 0; end
`endif
        end
      end else if (m_blk[i]) begin
        if (!r) m_blk[i] = 0;
      end else if (m_run[i] > 0 && sv) begin
        m_run[i] = 0; m_blk[i] = r;
      end else if (r) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_pend[i] = 1; m_pulse[i] = 1; m_age[i] = 0; m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cmp_model(input string name);
    logic [4:0] eo, ep;
    logic [2:0] ec;
    ec = 0;
    for (int i = 0; i < 5; i++) begin
      eo[i] = m_pulse[i];
      ep[i] = m_pend[i];
      ec = ec + 3'(m_pend[i]);
    end
    chk3(name, eo, ep, ec);
  endtask

  task automatic set_cars(input logic [2:0] ff, input logic fu, input logic fd,
                          input logic [2:0] sf, input logic su, input logic sd);
    ffloor = ff; fgoing_up = fu; fgoing_down = fd;
    sfloor = sf; sgoing_up = su; sgoing_down = sd;
  endtask

  task automatic async_reset_check(input string name);
    #2 reset = 1'b0;
    #1 chk3(name, 5'b0, 5'b0, 3'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{5'b00100, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[1]  = '{5'b00100, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[2]  = '{5'b00100, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[3]  = '{5'b00100, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00100, 5'b00100, 3'd1};
    tbl[4]  = '{5'b00000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00100, 3'd1};
    tbl[5]  = '{5'b00001, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00100, 3'd1};
    tbl[6]  = '{5'b00001, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00100, 3'd1};
    tbl[7]  = '{5'b00001, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00100, 3'd1};
    tbl[8]  = '{5'b00000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00100, 3'd1};
    tbl[9]  = '{5'b00100, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[10] = '{5'b00100, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[11] = '{5'b00100, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[12] = '{5'b00000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[13] = '{5'b10010, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[14] = '{5'b10010, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[15] = '{5'b10010, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};
    tbl[16] = '{5'b10010, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b10010, 5'b10010, 3'd2};
    tbl[17] = '{5'b00000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b10010, 3'd2};
    tbl[18] = '{5'b10010, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b10010, 3'd2};
    tbl[19] = '{5'b10010, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b10010, 3'd2};
    tbl[20] = '{5'b00000, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b10010, 3'd2};
    tbl[21] = '{5'b00000, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00010, 3'd1};
    tbl[22] = '{5'b00000, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00010, 3'd1};
    tbl[23] = '{5'b00000, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 5'b00000, 5'b00010, 3'd1};
    tbl[24] = '{5'b00000, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0};

    reset = 1'b0;
    raw_buttons = '0;
    set_cars(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    chk3("reset", 5'b0, 5'b0, 3'd0);
    reset = 1'b1;

    for (int n = 0; n < 25; n++) begin
      raw_buttons = tbl[n].raw;
      set_cars(tbl[n].ff, tbl[n].fu, tbl[n].fd, tbl[n].sf, tbl[n].su, tbl[n].sd);
      step();
      chk3($sformatf("vec%0d", n), tbl[n].eo, tbl[n].ep, tbl[n].ec);
    end

    // floor 4 held unserved: re-issue every RI edges when enabled, service on a pulse edge wins
    set_cars(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    raw_buttons = 5'b01000;
    repeat (DB) step();
    chk3("f4_issue", 5'b01000, 5'b01000, 3'd1);
    raw_buttons = 5'b00000;
    for (int k = 1; k <= 2 * RI; k++) begin
      logic [4:0] eo;
      eo = 5'b0;
`ifdef HALL_CALL_REISSUE_EN
      if (k == RI) eo = 5'b01000;
`endif
      if (k == 2 * RI) set_cars(3'd0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
      step();
      if (k == 2 * RI) chk3("f4_served_on_pulse", 5'b0, 5'b0, 3'd0);
      else chk3($sformatf("f4_wait%0d", k), eo, 5'b01000, 3'd1);
    end
    set_cars(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // reset between edges discards calls; held buttons re-debounce afterwards
    raw_buttons = 5'b01001;
    repeat (DB) step();
    chk3("f14_issue", 5'b01001, 5'b01001, 3'd2);
    async_reset_check("async_reset");
    for (int k = 1; k < DB; k++) begin
      step();
      chk3($sformatf("rearm%0d", k), 5'b0, 5'b0, 3'd0);
    end
    step();
    chk3("rearm_issue", 5'b01001, 5'b01001, 3'd2);

    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(7) == 0) raw_buttons[i] = ~raw_buttons[i];
      if ($urandom_range(3) == 0) ffloor = 3'($urandom_range(7));
      if ($urandom_range(3) == 0) sfloor = 3'($urandom_range(7));
      if ($urandom_range(5) == 0) begin fgoing_up = 1'b0; fgoing_down = 1'b0; end
      else begin fgoing_up = 1'($urandom_range(1)); fgoing_down = ~fgoing_up; end
      if ($urandom_range(5) == 0) begin sgoing_up = 1'b0; sgoing_down = 1'b0; end
      else begin sgoing_down = 1'($urandom_range(1)); sgoing_up = ~sgoing_down; end
      if (n == 1000) async_reset_check("rand_reset");
      step();
      cmp_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
